// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-register-bus bridge: ASCII constants,
// FSM/reply encodings and hex conversion helpers.
package uart_bridge_pkg;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EOL,
    ST_DISCARD,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_RD_WAIT,
    ST_REPLY
  } state_t;

  typedef enum logic [1:0] {
    RPL_OK,
    RPL_ER,
    RPL_DATA
  } reply_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_nib_t;

  // Case-insensitive ASCII hex digit to nibble; valid=0 for any other byte.
  function automatic hex_nib_t hex_to_nib(input logic [7:0] c);
    hex_nib_t   r;
    logic [7:0] lc;
    lc      = c | 8'h20;
    r.valid = 1'b1;
    r.nib   = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)        r.nib = c[3:0];
    else if (lc >= 8'h61 && lc <= 8'h66) r.nib = c[3:0] + 4'd9;
    else                                 r.valid = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_bridge_tx_seq.sv
// Reply sequencer: builds the ASCII reply into a small buffer and paces it
// into the UART TX FIFO with one idle cycle after every enqueue strobe.
module uart_bridge_tx_seq
  import uart_bridge_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  reply_t            kind,
  input  logic [DATA_W-1:0] rdata,
  input  logic              tx_fifo_full,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              done
);

  localparam int ND      = DATA_W / 4;
  localparam int BUF_LEN = (ND + 2 > 4) ? ND + 2 : 4;
  localparam int IDX_W   = $clog2(BUF_LEN + 1);
  localparam int DEPTH   = 2 ** IDX_W;

  logic [7:0]       buf_q [DEPTH];
  logic [7:0]       buf_d [DEPTH];
  logic [IDX_W-1:0] len_q, len_d, idx_q;
  logic             busy_q, gap_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    for (int i = 0; i < DEPTH; i++) buf_d[i] = 8'h00;
    len_d = IDX_W'(4);
    case (kind)
      RPL_OK: begin
        buf_d[0] = CH_O;  buf_d[1] = CH_K;
        buf_d[2] = CH_CR; buf_d[3] = CH_LF;
      end
      RPL_DATA: begin
        for (int i = 0; i < ND; i++) buf_d[i] = nib_to_hex(rdata[(ND-1-i)*4 +: 4]);
        buf_d[ND]   = CH_CR;
        buf_d[ND+1] = CH_LF;
        len_d       = IDX_W'(ND + 2);
      end
      default: begin
        buf_d[0] = CH_E;  buf_d[1] = CH_R;
        buf_d[2] = CH_CR; buf_d[3] = CH_LF;
      end
    endcase
  end

  // Gated directly by the live full flag; gap_q enforces the idle cycle after each strobe.
  assign tx_start = busy_q && !gap_q && (idx_q != len_q) && !tx_fifo_full;
  assign tx_data  = tx_start ? buf_q[idx_q] : 8'h00;
  assign done     = busy_q && !gap_q && (idx_q == len_q);

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      gap_q  <= 1'b0;
      idx_q  <= '0;
      len_q  <= '0;
      // NOTE: the buffer is only a few bytes of flops, so it is reset like any other state rather than left as RAM.
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'h00;
    end else if (load) begin
      buf_q  <= buf_d;
      len_q  <= len_d;
      idx_q  <= '0;
      busy_q <= 1'b1;
      gap_q  <= 1'b0;
    end else if (busy_q) begin
      if (tx_start) begin
        idx_q <= idx_q + IDX_W'(1);
        gap_q <= 1'b1;
      end else begin
        gap_q <= 1'b0;
      end
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// ASCII command bridge: parses "W<addr><data>CR" / "R<addr>CR" hex commands from
// the UART RX side, runs one register-bus transaction and queues an ASCII reply.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ready,
  input  logic [7:0]        rx_byte,
  output logic              rx_read,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_fifo_full,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid
);

  localparam int AD    = ADDR_W / 4;
  localparam int DD    = DATA_W / 4;
  localparam int CNT_W = $clog2(((AD > DD) ? AD : DD) + 1);
  localparam int TO_W  = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] AD_LAST = CNT_W'(AD - 1);
  localparam logic [CNT_W-1:0] DD_LAST = CNT_W'(DD - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(RD_TIMEOUT - 1);

  state_t            state, nxt_state;
  logic              is_write;
  logic [CNT_W-1:0]  dig_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  hex_nib_t          hx;
  logic              receiving, accept, is_cr, is_lf, is_w, is_r, last_digit;
  logic              reply_load, tx_done;
  reply_t            reply_kind;

  assign receiving  = state inside {ST_IDLE, ST_ADDR, ST_DATA, ST_EOL, ST_DISCARD};
  assign accept     = rx_ready && !rx_read && receiving;
  assign hx         = hex_to_nib(rx_byte);
  assign is_cr      = (rx_byte == CH_CR);
  assign is_lf      = (rx_byte == CH_LF);
  assign is_w       = ((rx_byte & 8'hDF) == CH_W);
  assign is_r       = ((rx_byte & 8'hDF) == CH_R);
  assign last_digit = (state == ST_ADDR) ? (dig_cnt == AD_LAST) : (dig_cnt == DD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state  = state;
    reply_load = 1'b0;
    reply_kind = RPL_ER;
    case (state)
      ST_IDLE:
        if (accept && !is_lf) begin
          if (is_w || is_r) nxt_state = ST_ADDR;
          else if (!is_cr)  nxt_state = ST_DISCARD;
        end
      ST_ADDR, ST_DATA:
        if (accept && !is_lf) begin
          if (hx.valid) begin
            if (last_digit) nxt_state = (state == ST_ADDR && is_write) ? ST_DATA : ST_EOL;
          end else if (is_cr) begin
            reply_load = 1'b1;
            nxt_state  = ST_REPLY;
          end else begin
            nxt_state = ST_DISCARD;
          end
        end
      ST_EOL:
        if (accept && !is_lf)
          nxt_state = !is_cr ? ST_DISCARD : (is_write ? ST_BUS_WR : ST_BUS_RD);
      ST_DISCARD:
        if (accept && is_cr) begin
          reply_load = 1'b1;
          nxt_state  = ST_REPLY;
        end
      ST_BUS_WR: begin
        reply_load = 1'b1;
        reply_kind = RPL_OK;
        nxt_state  = ST_REPLY;
      end
      ST_BUS_RD, ST_RD_WAIT:
        if (bus_rvalid) begin
          reply_load = 1'b1;
          reply_kind = RPL_DATA;
          nxt_state  = ST_REPLY;
        end else if (state == ST_RD_WAIT && to_cnt == TO_LAST) begin
          reply_load = 1'b1;
          nxt_state  = ST_REPLY;
        end else begin
          nxt_state = ST_RD_WAIT;
        end
      ST_REPLY:
        if (tx_done) nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_we = (state == ST_BUS_WR);
    bus_re = (state == ST_BUS_RD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_read   <= 1'b0;
      is_write  <= 1'b0;
      dig_cnt   <= '0;
      to_cnt    <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      if (accept)         rx_read <= 1'b1;
      else if (!rx_ready) rx_read <= 1'b0;

      if (state == ST_IDLE) dig_cnt <= '0;
      if (accept && !is_lf) begin
        case (state)
          ST_IDLE: if (is_w || is_r) is_write <= is_w;
          ST_ADDR:
            if (hx.valid) begin
              addr_sh <= (addr_sh << 4) | ADDR_W'(hx.nib);
              dig_cnt <= last_digit ? '0 : dig_cnt + CNT_W'(1);
            end
          ST_DATA:
            if (hx.valid) begin
              data_sh <= (data_sh << 4) | DATA_W'(hx.nib);
              dig_cnt <= last_digit ? '0 : dig_cnt + CNT_W'(1);
            end
          // Bus outputs latch only on a complete command so they hold between commands.
          ST_EOL:
            if (is_cr) begin
              bus_addr <= addr_sh;
              if (is_write) bus_wdata <= data_sh;
            end
          default: ;
        endcase
      end

      if (state == ST_BUS_RD)       to_cnt <= '0;
      else if (state == ST_RD_WAIT) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  uart_bridge_tx_seq #(.DATA_W(DATA_W)) u_tx_seq (
    .clk          (clk),
    .rst          (rst),
    .load         (reply_load),
    .kind         (reply_kind),
    .rdata        (bus_rdata),
    .tx_fifo_full (tx_fifo_full),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .done         (tx_done)
  );

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge: directed scenarios plus random command
// lines, checked against a line-level parser model and a TX/bus monitor.
module tb_uart_reg_bridge;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 255;
  localparam int AD = AW / 4;
  localparam int DD = DW / 4;

  typedef byte unsigned bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_read;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_fifo_full = 1'b0;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_we, bus_re;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_rvalid = 1'b0;

  always #5 clk = ~clk;

  uart_reg_bridge #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_ready(rx_ready), .rx_byte(rx_byte), .rx_read(rx_read),
    .tx_start(tx_start), .tx_data(tx_data), .tx_fifo_full(tx_fifo_full),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: everything sampled on the falling edge.
  byte unsigned   tx_q[$];
  logic [AW+DW-1:0] we_q[$];
  logic [AW-1:0]  re_q[$];
  int   cyc = 0, re_cyc = 0, first_tx_cyc = -1;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      check("tx_gated_by_full", tx_fifo_full, 1'b0);
      check("tx_idle_after_pulse", prev_start, 1'b0);
      tx_q.push_back(tx_data);
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
    end
    prev_start = tx_start;
    if (bus_we) we_q.push_back({bus_addr, bus_wdata});
    if (bus_re) begin
      re_q.push_back(bus_addr);
      re_cyc = cyc;
    end
  end

  // Bus read responder; delay 0 answers in the same cycle as bus_re.
  logic          rd_respond = 1'b1;
  int            rd_delay = 0;
  logic [DW-1:0] rd_value = '0;

  initial forever begin
    @(negedge clk);
    if (bus_re && rd_respond) begin
      repeat (rd_delay) @(posedge clk);
      if (rd_delay > 0) #1;
      bus_rvalid = 1'b1;
      bus_rdata  = rd_value;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      bus_rdata  = DW'($urandom);
    end
  end

  // ---------------- reference model ----------------
  function automatic int hexval(input byte unsigned c);
    if (c >= 8'h30 && c <= 8'h39) return c - 8'h30;
    if (c >= 8'h41 && c <= 8'h46) return c - 8'h37;
    if (c >= 8'h61 && c <= 8'h66) return c - 8'h57;
    return -1;
  endfunction

  // kind: 0 no reply, 1 write, 2 read, 3 error. line ends with its CR.
  function automatic void model(input bq_t line, output int kind,
                                output logic [AW-1:0] addr, output logic [DW-1:0] data);
    bq_t s;
    int  need, v;
    logic wr;
    kind = 3; addr = '0; data = '0;
    foreach (line[i]) if (line[i] != 8'h0A && line[i] != 8'h0D) s.push_back(line[i]);
    if (s.size() == 0) begin kind = 0; return; end
    if (s[0] == "W" || s[0] == "w")      wr = 1'b1;
    else if (s[0] == "R" || s[0] == "r") wr = 1'b0;
    else return;
    need = 1 + AD + (wr ? DD : 0);
    if (s.size() != need) return;
    for (int i = 1; i < need; i++) begin
      v = hexval(s[i]);
      if (v < 0) return;
      if (i <= AD) addr = addr * 16 + AW'(v);
      else         data = data * 16 + DW'(v);
    end
    kind = wr ? 1 : 2;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(8'h0D);
    return q;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input byte unsigned b);
    int t;
    rx_byte  = b;
    rx_ready = 1'b1;
    t = 0;
    while (rx_read !== 1'b1 && t < 3000) begin @(posedge clk); #1; t++; end
    check("rx_accept", rx_read, 1'b1);
    rx_ready = 1'b0;
    t = 0;
    while (rx_read !== 1'b0 && t < 50) begin @(posedge clk); #1; t++; end
    check("rx_release", rx_read, 1'b0);
  endtask

  task automatic clear_mon();
    tx_q.delete(); we_q.delete(); re_q.delete();
    first_tx_cyc = -1;
  endtask

  task automatic expect_bytes(input string tag, input bq_t exp);
    int t;
    t = 0;
    while (tx_q.size() < exp.size() && t < 1500) begin @(posedge clk); #1; t++; end
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_len"}, tx_q.size(), exp.size());
    foreach (exp[i]) if (i < tx_q.size()) check({tag, "_byte"}, tx_q[i], exp[i]);
  endtask

  task automatic run_line(input string tag, input bq_t line,
                          input logic respond, input int delay, input logic [DW-1:0] value);
    int            kind;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bq_t           exp;
    string         hexs;
    hexs = "0123456789ABCDEF";
    clear_mon();
    rd_respond = respond; rd_delay = delay; rd_value = value;
    model(line, kind, ea, ed);
    case (kind)
      1: exp = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
      2: if (respond) begin
           for (int i = DD - 1; i >= 0; i--) exp.push_back(hexs[(value >> (4 * i)) & 'hF]);
           exp.push_back(8'h0D); exp.push_back(8'h0A);
         end else exp = '{8'h45, 8'h52, 8'h0D, 8'h0A};
      3: exp = '{8'h45, 8'h52, 8'h0D, 8'h0A};
      default: exp = {};
    endcase
    foreach (line[i]) send_byte(line[i]);
    expect_bytes(tag, exp);
    check({tag, "_we_count"}, we_q.size(), (kind == 1) ? 1 : 0);
    check({tag, "_re_count"}, re_q.size(), (kind == 2) ? 1 : 0);
    if (kind == 1 && we_q.size() > 0) check({tag, "_we_addr_data"}, we_q[0], {ea, ed});
    if (kind == 2 && re_q.size() > 0) check({tag, "_re_addr"}, re_q[0], ea);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_read"}, rx_read, 1'b0);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_bus_addr"}, bus_addr, '0);
    check({tag, "_bus_wdata"}, bus_wdata, '0);
    check({tag, "_bus_we"}, bus_we, 1'b0);
    check({tag, "_bus_re"}, bus_re, 1'b0);
  endtask

  function automatic byte unsigned rand_hex();
    int n;
    n = $urandom_range(0, 15);
    if (n < 10) return 8'(8'h30 + n);
    return 8'(($urandom_range(0, 1) ? 8'h41 : 8'h61) + n - 10);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t line;
    int  t, ty;
    byte unsigned c;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_line("w3a5c", str2q("W3A5C"), 1'b1, 0, '0);
    check("w3a5c_bus", we_q.size() > 0 ? we_q[0] : '0, 16'h3A5C);

    run_line("r3a", str2q("r3a"), 1'b1, 3, 8'hE7);
    check("r3a_addr", re_q.size() > 0 ? re_q[0] : '0, 8'h3A);
    check("r3a_reply0", tx_q.size() > 0 ? tx_q[0] : 8'h00, 8'h45);
    check("r3a_reply1", tx_q.size() > 1 ? tx_q[1] : 8'h00, 8'h37);

    run_line("rd_same_cycle", str2q("R5b"), 1'b1, 0, 8'h9C);

    run_line("rff_timeout", str2q("RFF"), 1'b0, 0, '0);
    check("rff_no_we", we_q.size(), 0);
    check("rff_wait_min", (first_tx_cyc - re_cyc) >= TO, 1'b1);
    check("rff_wait_max", (first_tx_cyc - re_cyc) <= TO + 4, 1'b1);

    run_line("wg1_bad", str2q("WG1"), 1'b1, 0, '0);
    run_line("w0102", str2q("W0102"), 1'b1, 0, '0);
    check("w0102_bus", we_q.size() > 0 ? we_q[0] : '0, 16'h0102);

    // TX FIFO full for 100 cycles in the middle of a reply, with an LF offered meanwhile.
    clear_mon();
    line = str2q("W3A5C");
    foreach (line[i]) send_byte(line[i]);
    t = 0;
    while (tx_q.size() < 1 && t < 200) begin @(posedge clk); #1; t++; end
    tx_fifo_full = 1'b1;
    rx_byte = 8'h0A; rx_ready = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("full_no_progress", tx_q.size(), 1);
    check("full_rx_blocked", rx_read, 1'b0);
    tx_fifo_full = 1'b0;
    t = 0;
    while (rx_read !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    check("full_rx_after_reply", rx_read, 1'b1);
    check("full_reply_done_first", tx_q.size(), 4);
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_bytes("full_reply", '{8'h4F, 8'h4B, 8'h0D, 8'h0A});

    // Reset in the middle of a reply.
    clear_mon();
    line = str2q("W3A5C");
    foreach (line[i]) send_byte(line[i]);
    t = 0;
    while (tx_q.size() < 2 && t < 200) begin @(posedge clk); #1; t++; end
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    we_q.delete(); re_q.delete();
    repeat (20) @(posedge clk);
    #1;
    check("mid_reset_abandoned", tx_q.size(), 2);
    check("mid_reset_no_strobe", we_q.size() + re_q.size(), 0);
    run_line("after_reset", str2q("W0011"), 1'b1, 0, '0);

    // Random command lines.
    for (int k = 0; k < 40; k++) begin
      line = {};
      ty = $urandom_range(0, 6);
      c = (ty == 1 || (ty > 2 && $urandom_range(0, 1))) ? "R" : "W";
      if ($urandom_range(0, 1)) c = c | 8'h20;
      if (ty == 2) begin
        do c = 8'($urandom_range(8'h21, 8'h7E));
        while ((c & 8'hDF) == "W" || (c & 8'hDF) == "R");
      end
      if (ty != 6) line.push_back(c);
      if (ty != 6)
        for (int i = 0; i < AD + (((c & 8'hDF) == "W") ? DD : 0); i++) line.push_back(rand_hex());
      if (ty == 3 && line.size() > 1) line[$urandom_range(1, line.size() - 1)] = 8'(8'h47 + $urandom_range(0, 10));
      if (ty == 4 && line.size() > 1) line = line[0 : $urandom_range(0, line.size() - 2)];
      if (ty == 5) line.push_back(rand_hex());
      line.push_back(8'h0D);
      repeat ($urandom_range(0, 2)) line.insert($urandom_range(0, line.size() - 1), 8'h0A);
      run_line("rand", line, ($urandom_range(0, 7) != 0), $urandom_range(0, 4), DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
